// File: rtl/uart_rx_deserializer.sv
// rtl/uart_rx_deserializer.sv - UART receive path: synchronizer, start qualification, majority-vote sampling, parity/stop check
module uart_rx_deserializer #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                  state, state_d;
  logic                    rx_meta, rx_s;
  logic [PRESCALE_W-1:0]   edge_cnt;
  logic [BW-1:0]           bit_cnt;
  logic [PRESCALE_W-1:0]   presc_q;
  logic                    par_en_q, par_typ_q;
  logic                    s0, s1, sample;
  logic [DATA_WIDTH-1:0]   shreg;
  logic                    par_bad;

  logic [PRESCALE_W-1:0]   mid, mid_lo, mid_hi, last;
  logic                    last_edge, vote, par_exp;

  assign mid       = {1'b0, presc_q[PRESCALE_W-1:1]};
  assign mid_lo    = mid - PRESCALE_W'(1);
  assign mid_hi    = mid + PRESCALE_W'(1);
  assign last      = presc_q - PRESCALE_W'(1);
  assign last_edge = (edge_cnt == last);
  assign vote      = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
  assign par_exp   = (^shreg) ^ par_typ_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (!rx_s) state_d = START;
      START:   if (last_edge) state_d = sample ? IDLE : DATA;
      DATA:    if (last_edge && bit_cnt == BW'(DATA_WIDTH - 1))
                 state_d = par_en_q ? PARITY : STOP;
      PARITY:  if (last_edge) state_d = STOP;
      STOP:    if (last_edge) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta    <= 1'b1;
      rx_s       <= 1'b1;
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      presc_q    <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      s0         <= 1'b1;
      s1         <= 1'b1;
      sample     <= 1'b1;
      shreg      <= '0;
      par_bad    <= 1'b0;
      P_DATA     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      rx_meta    <= RX_IN;
      rx_s       <= rx_meta;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      if (state == IDLE) begin
        bit_cnt <= '0;
        par_bad <= 1'b0;
        edge_cnt <= '0;
        // The detection cycle is edge 0, so the counter leaves IDLE at 1.
        if (!rx_s) begin
          edge_cnt  <= PRESCALE_W'(1);
          presc_q   <= prescale;
          par_en_q  <= PAR_EN;
          par_typ_q <= PAR_TYP;
        end
      end else begin
        edge_cnt <= last_edge ? '0 : edge_cnt + PRESCALE_W'(1);
        if (edge_cnt == mid_lo) s0 <= rx_s;
        if (edge_cnt == mid)    s1 <= rx_s;
        if (edge_cnt == mid_hi) sample <= vote;
        if (last_edge) begin
          case (state)
            DATA: begin
              shreg   <= {sample, shreg[DATA_WIDTH-1:1]};
              bit_cnt <= bit_cnt + BW'(1);
            end
            PARITY: par_bad <= (sample != par_exp);
            STOP: begin
              stp_err <= ~sample;
              par_err <= par_bad;
              if (sample && !par_bad) begin
                data_valid <= 1'b1;
                P_DATA     <= shreg;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// tb/tb_uart_rx_deserializer.sv - directed self-checking bench for uart_rx_deserializer
module tb_uart_rx_deserializer;

  logic       clk;
  logic       rst;
  logic       RX_IN;
  logic [5:0] prescale;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int c;

  int         dv_cyc[$];
  logic [7:0] dv_data[$];
  int         pe_cyc[$];
  int         se_cyc[$];

  uart_rx_deserializer #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .RX_IN      (RX_IN),
    .prescale   (prescale),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .P_DATA     (P_DATA),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stp_err    (stp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe recorder: each high cycle is logged, so a two-cycle strobe shows as two entries.
  always @(negedge clk) begin
    if (data_valid) begin
      dv_cyc.push_back(cyc);
      dv_data.push_back(P_DATA);
    end
    if (par_err) pe_cyc.push_back(cyc);
    if (stp_err) se_cyc.push_back(cyc);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    dv_cyc.delete();
    dv_data.delete();
    pe_cyc.delete();
    se_cyc.delete();
  endtask

  function automatic int qi(input int idx, input int which);
    case (which)
      0: qi = (dv_cyc.size() > idx) ? dv_cyc[idx] : -1;
      1: qi = (dv_data.size() > idx) ? int'(dv_data[idx]) : -1;
      2: qi = (pe_cyc.size() > idx) ? pe_cyc[idx] : -1;
      default: qi = (se_cyc.size() > idx) ? se_cyc[idx] : -1;
    endcase
  endfunction

  task automatic drive_bit(input logic b, input int p);
    RX_IN = b;
    repeat (p) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input int p, input logic has_par,
                            input logic par_bit, input logic stop_bit);
    drive_bit(1'b0, p);
    for (int i = 0; i < 8; i++) drive_bit(d[i], p);
    if (has_par) drive_bit(par_bit, p);
    drive_bit(stop_bit, p);
    RX_IN = 1'b1;
  endtask

  initial begin
    rst = 1'b1; RX_IN = 1'b1; prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_p_data", 32'(P_DATA), 32'h0);
    check("rst_dv", 32'(data_valid), 32'h0);
    check("rst_pe", 32'(par_err), 32'h0);
    check("rst_se", 32'(stp_err), 32'h0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // prescale 8, no parity, 0xA5
    clear_log();
    c = cyc;
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
    repeat (6) @(negedge clk);
    check("a5_dv_count", 32'(dv_cyc.size()), 32'd1);
    check("a5_dv_cycle", 32'(qi(0, 0)), 32'(c + 2 + 80));
    check("a5_data", 32'(qi(0, 1)), 32'hA5);
    check("a5_pe_count", 32'(pe_cyc.size()), 32'd0);
    check("a5_se_count", 32'(se_cyc.size()), 32'd0);

    // prescale 16, even parity, good parity
    prescale = 6'd16; PAR_EN = 1'b1; PAR_TYP = 1'b0;
    repeat (4) @(negedge clk);
    clear_log();
    c = cyc;
    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1);
    repeat (6) @(negedge clk);
    check("3c_dv_count", 32'(dv_cyc.size()), 32'd1);
    check("3c_dv_cycle", 32'(qi(0, 0)), 32'(c + 2 + 176));
    check("3c_data", 32'(qi(0, 1)), 32'h3C);
    check("3c_pe_count", 32'(pe_cyc.size()), 32'd0);

    // same frame with wrong parity bit
    clear_log();
    c = cyc;
    send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b1);
    repeat (6) @(negedge clk);
    check("3c_bad_pe_count", 32'(pe_cyc.size()), 32'd1);
    check("3c_bad_pe_cycle", 32'(qi(0, 2)), 32'(c + 2 + 176));
    check("3c_bad_dv_count", 32'(dv_cyc.size()), 32'd0);
    check("3c_bad_se_count", 32'(se_cyc.size()), 32'd0);
    check("3c_bad_p_data_hold", 32'(P_DATA), 32'h3C);

    // prescale 32, odd parity, correct parity bit, stop bit low
    prescale = 6'd32; PAR_EN = 1'b1; PAR_TYP = 1'b1;
    repeat (4) @(negedge clk);
    clear_log();
    c = cyc;
    send_frame(8'h01, 32, 1'b1, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    check("01_se_count", 32'(se_cyc.size()), 32'd1);
    check("01_se_cycle", 32'(qi(0, 3)), 32'(c + 2 + 352));
    check("01_pe_count", 32'(pe_cyc.size()), 32'd0);
    check("01_dv_count", 32'(dv_cyc.size()), 32'd0);
    check("01_p_data_hold", 32'(P_DATA), 32'h3C);

    // prescale 16, 3-cycle glitch must be rejected
    prescale = 6'd16; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    repeat (4) @(negedge clk);
    clear_log();
    RX_IN = 1'b0;
    repeat (3) @(negedge clk);
    RX_IN = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_dv", 32'(dv_cyc.size()), 32'd0);
    check("glitch_pe", 32'(pe_cyc.size()), 32'd0);
    check("glitch_se", 32'(se_cyc.size()), 32'd0);

    // prescale 8, three frames back-to-back
    prescale = 6'd8;
    repeat (4) @(negedge clk);
    clear_log();
    c = cyc;
    send_frame(8'h00, 8, 1'b0, 1'b0, 1'b1);
    send_frame(8'hFF, 8, 1'b0, 1'b0, 1'b1);
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1);
    repeat (6) @(negedge clk);
    check("b2b_dv_count", 32'(dv_cyc.size()), 32'd3);
    check("b2b_cycle0", 32'(qi(0, 0)), 32'(c + 2 + 80));
    check("b2b_cycle1", 32'(qi(1, 0)), 32'(c + 2 + 160));
    check("b2b_cycle2", 32'(qi(2, 0)), 32'(c + 2 + 240));
    check("b2b_data0", 32'(qi(0, 1)), 32'h00);
    check("b2b_data1", 32'(qi(1, 1)), 32'hFF);
    check("b2b_data2", 32'(qi(2, 1)), 32'h5A);
    check("b2b_err_count", 32'(pe_cyc.size() + se_cyc.size()), 32'd0);

    // prescale 16, reset during data bit 4 of 0xC3, then clean 0x7E
    prescale = 6'd16;
    repeat (4) @(negedge clk);
    clear_log();
    drive_bit(1'b0, 16);
    for (int i = 0; i < 4; i++) drive_bit(1'(8'hC3 >> i), 16);
    drive_bit(1'b0, 8);
    rst = 1'b1;
    RX_IN = 1'b1;
    @(negedge clk);
    check("mid_rst_p_data", 32'(P_DATA), 32'h0);
    check("mid_rst_dv", 32'(data_valid), 32'h0);
    check("mid_rst_pe", 32'(par_err), 32'h0);
    check("mid_rst_se", 32'(stp_err), 32'h0);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    check("abort_no_strobes", 32'(dv_cyc.size() + pe_cyc.size() + se_cyc.size()), 32'd0);
    clear_log();
    c = cyc;
    send_frame(8'h7E, 16, 1'b0, 1'b0, 1'b1);
    repeat (6) @(negedge clk);
    check("7e_dv_count", 32'(dv_cyc.size()), 32'd1);
    check("7e_dv_cycle", 32'(qi(0, 0)), 32'(c + 2 + 160));
    check("7e_data", 32'(qi(0, 1)), 32'h7E);
    check("7e_p_data", 32'(P_DATA), 32'h7E);
    check("7e_err_count", 32'(pe_cyc.size() + se_cyc.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
